// File: rtl/finger_dance_core_pkg.sv
// Shared definitions for the finger-dance game engine: state codes,
// LFSR tap mask and default seed.
package finger_dance_core_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_GAP  = 3'd1,
        ST_WAIT = 3'd2,
        ST_OVER = 3'd3
    } state_e;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/finger_dance_lfsr.sv
// Free-running 16-bit Fibonacci LFSR; exposes the raw register state.
module finger_dance_lfsr
    import finger_dance_core_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] state_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_next(lfsr_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/finger_dance_core.sv
// Finger-dance game engine: random target lanes, response-window timing,
// hit/miss scoring, level-based speed-up and game-over after a miss limit.
module finger_dance_core
    import finger_dance_core_pkg::*;
#(
    parameter int          NUM_LANES   = 4,
    parameter int          LANE_W      = 4,
    parameter int          SCORE_W     = 8,
    parameter int          WINDOW_INIT = 25_000_000,
    parameter int          WINDOW_STEP = 2_500_000,
    parameter int          WINDOW_MIN  = 5_000_000,
    parameter int          GAP_CYCLES  = 5_000_000,
    parameter int          LEVEL_HITS  = 8,
    parameter int          MAX_MISSES  = 3,
    parameter logic [15:0] SEED        = LFSR_SEED_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               key_valid,
    input  logic [LANE_W-1:0]  key_code,
    output logic               target_valid,
    output logic [LANE_W-1:0]  target_lane,
    output logic               hit_pulse,
    output logic               miss_pulse,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         misses,
    output logic [3:0]         level,
    output logic               game_over,
    output logic [2:0]         state
);

    localparam logic [31:0]       WIN_INIT   = 32'(WINDOW_INIT);
    localparam logic [31:0]       WIN_STEP   = 32'(WINDOW_STEP);
    localparam logic [31:0]       WIN_MIN    = 32'(WINDOW_MIN);
    localparam logic [32:0]       STEP_THR   = 33'(WINDOW_MIN) + 33'(WINDOW_STEP);
    localparam logic [31:0]       GAP_LOAD   = 32'(GAP_CYCLES - 1);
    localparam logic [31:0]       LANES32    = 32'(NUM_LANES);
    localparam logic [LANE_W:0]   LANE_LIMIT = (LANE_W + 1)'(NUM_LANES);
    localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(NUM_LANES - 1);
    localparam int                HL_W       = (LEVEL_HITS > 1) ? $clog2(LEVEL_HITS) : 1;
    localparam logic [HL_W-1:0]   HL_LAST    = HL_W'(LEVEL_HITS - 1);
    localparam logic [3:0]        MISS_LIMIT = 4'(MAX_MISSES);

    state_e             state_q, state_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [31:0]        window_q, window_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [3:0]         misses_q, misses_d;
    logic [3:0]         level_q, level_d;
    logic [HL_W-1:0]    hits_q, hits_d;
    logic               target_valid_q, target_valid_d;
    logic [LANE_W-1:0]  target_lane_q, target_lane_d;
    logic               hit_q, hit_d;
    logic               miss_q, miss_d;

    logic [15:0]        lfsr_state;
    logic               unused_lfsr_hi;
    logic [LANE_W-1:0]  cand_lane;
    logic [LANE_W-1:0]  next_lane;
    logic               key_ok;

    finger_dance_lfsr #(
        .SEED(SEED)
    ) u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .state_o(lfsr_state)
    );

    assign unused_lfsr_hi = ^lfsr_state[15:8];

    // target_lane_q doubles as the previous target for the anti-repeat rule
    always_comb begin
        cand_lane = LANE_W'({24'd0, lfsr_state[7:0]} % LANES32);
        next_lane = cand_lane;
        if (cand_lane == target_lane_q) begin
            next_lane = (cand_lane == LAST_LANE) ? '0 : cand_lane + LANE_W'(1);
        end
    end

    assign key_ok = key_valid && ({1'b0, key_code} < LANE_LIMIT);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        window_d       = window_q;
        score_d        = score_q;
        misses_d       = misses_q;
        level_d        = level_q;
        hits_d         = hits_q;
        target_valid_d = target_valid_q;
        target_lane_d  = target_lane_q;
        hit_d          = 1'b0;
        miss_d         = 1'b0;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    score_d        = '0;
                    misses_d       = '0;
                    level_d        = '0;
                    hits_d         = '0;
                    window_d       = WIN_INIT;
                    target_lane_d  = '0;
                    target_valid_d = 1'b0;
                    cnt_d          = GAP_LOAD;
                    state_d        = ST_GAP;
                end
            end

            ST_GAP: begin
                if (cnt_q == '0) begin
                    target_lane_d  = next_lane;
                    target_valid_d = 1'b1;
                    cnt_d          = window_q - 32'd1;
                    state_d        = ST_WAIT;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end

            ST_WAIT: begin
                // a valid key wins over a same-cycle timer expiry
                if (key_ok) begin
                    if (key_code == target_lane_q) begin
                        hit_d = 1'b1;
                    end else begin
                        miss_d = 1'b1;
                    end
                end else if (cnt_q == '0) begin
                    miss_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end

                if (hit_d) begin
                    if (score_q != '1) begin
                        score_d = score_q + SCORE_W'(1);
                    end
                    if (hits_q == HL_LAST) begin
                        hits_d = '0;
                        if (level_q != 4'hF) begin
                            level_d = level_q + 4'd1;
                        end
                        window_d = ({1'b0, window_q} >= STEP_THR) ? window_q - WIN_STEP : WIN_MIN;
                    end else begin
                        hits_d = hits_q + HL_W'(1);
                    end
                end

                if (miss_d) begin
                    misses_d = misses_q + 4'd1;
                end

                if (hit_d || miss_d) begin
                    target_valid_d = 1'b0;
                    cnt_d          = GAP_LOAD;
                    state_d        = (miss_d && (misses_d == MISS_LIMIT)) ? ST_OVER : ST_GAP;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            window_q       <= WIN_INIT;
            score_q        <= '0;
            misses_q       <= '0;
            level_q        <= '0;
            hits_q         <= '0;
            target_valid_q <= 1'b0;
            target_lane_q  <= '0;
            hit_q          <= 1'b0;
            miss_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            window_q       <= window_d;
            score_q        <= score_d;
            misses_q       <= misses_d;
            level_q        <= level_d;
            hits_q         <= hits_d;
            target_valid_q <= target_valid_d;
            target_lane_q  <= target_lane_d;
            hit_q          <= hit_d;
            miss_q         <= miss_d;
        end
    end

    assign target_valid = target_valid_q;
    assign target_lane  = target_lane_q;
    assign hit_pulse    = hit_q;
    assign miss_pulse   = miss_q;
    assign score        = score_q;
    assign misses       = misses_q;
    assign level        = level_q;
    assign game_over    = (state_q == ST_OVER);
    assign state        = state_q;

endmodule
